div_ctrl: RTL
=============

Name: div_ctrl

Overview:
- Multi-cycle divider controller for the HILO path; executes DIV/DIVU as 32-step restoring division, one step per cycle.
- Sits beside the EX stage: EX raises start_i with operands and holds it, stalls the pipeline through stall_req_o, then takes {remainder, quotient} for the HI/LO write.
- Owns the divider FSM, iteration counter, operand latches, sign fix-up and annulment handling.

Parameters:
- WIDTH, 32, operand width; counter is clog2(WIDTH)+1 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  request a divide; held high by EX until ready_o is seen.
- annul_i  in  1  cancel the current operation (branch/flush).
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- result_o  out  2*WIDTH  {remainder, quotient}; HI = [2W-1:W], LO = [W-1:0].
- ready_o  out  1  result valid.
- stall_req_o  out  1  pipeline stall request.

Behaviour:
- Reset (rst low, async): state FREE, counter 0, result_o 0, ready_o 0, stall_req_o 0. Reset mid-operation discards all work; no partial result is ever presented.
- States: FREE, SHORT, ON, END.
- FREE:
  - start_i=1 and annul_i=0 at edge E0 latches the operands.
  - Signed mode: latch magnitudes and record sign_q = sign1^sign2, sign_r = sign1.
  - Divisor==0 -> SHORT. Otherwise -> ON with counter=0 and partial remainder 0.
  - start_i=1 with annul_i=1: stay FREE.
- SHORT: one cycle; next edge -> END with result_o=0 (divide-by-zero) or the early-out value (see Optional Feature).
- ON, each edge:
  - Shift {rem, dividend} left 1.
  - If the shifted rem >= divisor: subtract the divisor and set quotient bit 1, else quotient bit 0.
  - Counter increments.
  - The edge with counter==WIDTH -> END, applying the sign fix-up: quotient negated if sign_q, remainder negated if sign_r (signed mode only).
- annul_i=1 in ON or SHORT: next edge -> FREE, counter 0, result_o unchanged (0), ready_o stays 0.
- END:
  - ready_o=1, result_o held stable.
  - Stays in END while start_i=1.
  - start_i=0 -> FREE at the next edge; ready_o=0 and result_o=0 after that edge.
  - annul_i is ignored in END.
- Latency: ready_o is high after edge E(WIDTH+1), i.e. E33 for WIDTH=32. The divide-by-zero path is ready after E1.
- stall_req_o (combinational) = (FREE & start_i & ~annul_i) | ON | SHORT. It is 0 in END so the pipeline advances and EX drops start_i.
- Operand inputs are ignored after E0.
- Unsigned mode treats all bits as magnitude; no sign fix-up.
- Most-negative / -1 in signed mode: quotient 0x80000000, remainder 0 (natural wrap), no exception.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: in FREE, if |dividend| < |divisor| and divisor != 0, go to SHORT. END then presents quotient=0 and remainder = original signed dividend; ready_o is high after E1.
- Undefined: such operands take the full ON path; the result is identical and ready_o is high after E33.

Test Plan:
- Unsigned: opdata1=100, opdata2=7, signed_div_i=0, start held -> result_o=64'h00000002_0000000E; ready_o high after E33; stall_req_o high from E0 cycle through the cycle before END.
- Signed: opdata1=32'hFFFFFFF9 (-7), opdata2=2, signed_div_i=1 -> result_o=64'hFFFFFFFF_FFFFFFFD; also 7/-2 -> 64'h00000001_FFFFFFFD.
- Divide by zero: opdata1=5, opdata2=0 -> ready_o after E1, result_o=0; drop start_i -> FREE, ready_o=0 next edge.
- Annul mid-op: 100/7, annul_i=1 for one cycle at counter 10 -> FREE next edge, ready_o never asserts; a fresh start then yields 64'h00000002_0000000E.
- Reset mid-op: rst low asynchronously at counter 20 -> outputs 0 immediately, FREE; after release, 0xFFFFFFFF/1 unsigned -> 64'h00000000_FFFFFFFF.
- Early out: opdata1=5, opdata2=9 unsigned -> 64'h00000005_00000000; ready after E1 with DIV_EARLY_OUT_EN, after E33 without.

Source files
------------

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl -- multi-cycle restoring divider controller for the HILO path.
//
// Executes DIV (two's complement) and DIVU as a WIDTH-step restoring division,
// one quotient bit per clock. EX raises start_i with the operands and keeps it
// high; the block stalls the pipeline until the result is ready, then holds
// {remainder, quotient} until EX drops start_i.
//
// Optional build macro: DIV_EARLY_OUT_EN
//   When defined, operands with |dividend| < |divisor| (divisor != 0) skip the
//   iteration loop and finish in one cycle with quotient 0 and
//   remainder = original dividend.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   start_i      in   divide request, held until ready_o is seen
//   annul_i      in   cancel the operation in flight (ignored once done)
//   signed_div_i in   1 = signed divide, 0 = unsigned divide
//   opdata1_i    in   dividend (sampled only on the accepting edge)
//   opdata2_i    in   divisor  (sampled only on the accepting edge)
//   result_o     out  {remainder, quotient}; HI = upper half, LO = lower half
//   ready_o      out  result valid
//   stall_req_o  out  pipeline stall request (combinational)
// -----------------------------------------------------------------------------
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stall_req_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH);
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_SHORT = 2'd1,
        ST_ON    = 2'd2,
        ST_END   = 2'd3
    } state_t;

    // Two's complement negation of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + W_ONE;
    endfunction

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] rem_r;      // partial remainder
    logic [WIDTH-1:0] dvd_r;      // dividend magnitude, becomes the quotient
    logic [WIDTH-1:0] dvs_r;      // divisor magnitude
    logic             sign_q_r;   // quotient must be negated at the end
    logic             sign_r_r;   // remainder must be negated at the end

    logic             op1_neg_s;
    logic             op2_neg_s;
    logic [WIDTH-1:0] abs1_s;
    logic [WIDTH-1:0] abs2_s;
    logic [WIDTH:0]   trial_s;
    logic             ge_s;
    logic [WIDTH-1:0] next_rem_s;
    logic [WIDTH-1:0] q_fix_s;
    logic [WIDTH-1:0] r_fix_s;

    // Operand magnitudes, one restoring step and the final sign fix-up.
    always_comb begin
        op1_neg_s  = signed_div_i & opdata1_i[WIDTH-1];
        op2_neg_s  = signed_div_i & opdata2_i[WIDTH-1];
        abs1_s     = op1_neg_s ? negate(opdata1_i) : opdata1_i;
        abs2_s     = op2_neg_s ? negate(opdata2_i) : opdata2_i;
        // Shifted remainder needs one extra bit before the compare.
        trial_s    = {rem_r, dvd_r[WIDTH-1]};
        ge_s       = (trial_s >= {1'b0, dvs_r});
        // When ge_s holds the difference always fits in WIDTH bits.
        if (ge_s) begin
            next_rem_s = trial_s[WIDTH-1:0] - dvs_r;
        end else begin
            next_rem_s = trial_s[WIDTH-1:0];
        end
        q_fix_s    = sign_q_r ? negate(dvd_r) : dvd_r;
        r_fix_s    = sign_r_r ? negate(rem_r) : rem_r;
    end

    // Stall while a request is being accepted or the divider is busy.
    always_comb begin
        case (state_r)
            ST_FREE:  stall_req_o = start_i & ~annul_i;
            ST_SHORT: stall_req_o = 1'b1;
            ST_ON:    stall_req_o = 1'b1;
            ST_END:   stall_req_o = 1'b0;
            default:  stall_req_o = 1'b0;
        endcase
    end

    // Divider FSM, iteration datapath and registered result/ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_FREE;
            cnt_r    <= CNT_ZERO;
            rem_r    <= W_ZERO;
            dvd_r    <= W_ZERO;
            dvs_r    <= W_ZERO;
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            result_o <= {(2*WIDTH){1'b0}};
            ready_o  <= 1'b0;
        end else begin
            case (state_r)
                ST_FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= {(2*WIDTH){1'b0}};
                    if (start_i && !annul_i) begin
                        dvd_r    <= abs1_s;
                        dvs_r    <= abs2_s;
                        sign_q_r <= op1_neg_s ^ op2_neg_s;
                        sign_r_r <= op1_neg_s;
                        rem_r    <= W_ZERO;
                        cnt_r    <= CNT_ZERO;
                        if (abs2_s == W_ZERO) begin
                            state_r <= ST_SHORT;
`ifdef DIV_EARLY_OUT_EN
                        end else if (abs1_s < abs2_s) begin
                            state_r <= ST_SHORT;
`endif
                        end else begin
                            state_r <= ST_ON;
                        end
                    end else begin
                        state_r <= ST_FREE;
                    end
                end
                ST_SHORT: begin
                    if (annul_i) begin
                        state_r <= ST_FREE;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        state_r <= ST_END;
                        ready_o <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
                        // Non-zero divisor here means the early-out case:
                        // quotient 0, remainder is the signed dividend.
                        if (dvs_r != W_ZERO) begin
                            result_o <= {(sign_r_r ? negate(dvd_r) : dvd_r), W_ZERO};
                        end else begin
                            result_o <= {(2*WIDTH){1'b0}};
                        end
`else
                        result_o <= {(2*WIDTH){1'b0}};
`endif
                    end
                end
                ST_ON: begin
                    if (annul_i) begin
                        state_r <= ST_FREE;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r  <= ST_END;
                        ready_o  <= 1'b1;
                        result_o <= {r_fix_s, q_fix_s};
                    end else begin
                        rem_r <= next_rem_s;
                        dvd_r <= {dvd_r[WIDTH-2:0], ge_s};
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_END: begin
                    // annul_i deliberately not looked at: the result is final.
                    if (!start_i) begin
                        state_r  <= ST_FREE;
                        ready_o  <= 1'b0;
                        result_o <= {(2*WIDTH){1'b0}};
                        cnt_r    <= CNT_ZERO;
                    end else begin
                        state_r <= ST_END;
                    end
                end
                default: begin
                    state_r  <= ST_FREE;
                    cnt_r    <= CNT_ZERO;
                    ready_o  <= 1'b0;
                    result_o <= {(2*WIDTH){1'b0}};
                end
            endcase
        end
    end

endmodule
